// File: rtl/key_debounce_scan.sv
// Key debouncer: 2-flop sync, per-key saturating integrators updated by a
// time-multiplexed scan, atomic publish of the debounced vector.
module key_debounce_scan #(
  parameter int NUM_KEYS   = 61,
  parameter int CNT_W      = 4,
  parameter int TICK_DIV   = 470,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_g_int_buf,
  input  logic                rstn_g_i,
  input  logic [NUM_KEYS-1:0] keys_i_g,
  output logic [NUM_KEYS-1:0] keys_o,
  output logic                keys_changed_o,
  output logic                scan_busy_o,
  output logic                tick_o
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  if (TICK_DIV < NUM_KEYS + 4) begin : g_bad_div
    $error("TICK_DIV must be at least NUM_KEYS+4");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PUBLISH
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] work_q, work_d;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic                chg_q, chg_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  logic [NUM_KEYS-1:0] pressed_raw;
  logic                raw_bit;
  logic [CNT_W-1:0]    cnt_rd;
  logic [CNT_W-1:0]    cnt_wr;
  logic                tick;

  assign pressed_raw    = sync2_q ^ {NUM_KEYS{ACTIVE_LOW}};
  assign tick           = (pre_q == PRE_LAST);
  assign pre_d          = tick ? '0 : pre_q + PRE_W'(1);
  assign tick_o         = tick;
  assign keys_o         = keys_q;
  assign keys_changed_o = chg_q;
  assign scan_busy_o    = (state_q != IDLE);

  // Single read-modify-write of the integrator addressed by idx.
  always_comb begin
    raw_bit = pressed_raw[idx_q];
    cnt_rd  = cnt_q[idx_q];
    cnt_wr  = cnt_rd;
    if (raw_bit && cnt_rd != CNT_MAX) begin
      cnt_wr = cnt_rd + CNT_W'(1);
    end else if (!raw_bit && cnt_rd != '0) begin
      cnt_wr = cnt_rd - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    keys_d  = keys_q;
    chg_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        cnt_d[idx_q] = cnt_wr;
        if (cnt_wr == CNT_MAX) begin
          work_d[idx_q] = 1'b1;
        end else if (cnt_wr == '0) begin
          work_d[idx_q] = 1'b0;
        end
        // Output registers load on entry so they are valid during PUBLISH.
        if (idx_q == LAST_IDX) begin
          state_d = PUBLISH;
          keys_d  = work_d;
          chg_d   = (work_d != keys_q);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
    if (!rstn_g_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      work_q  <= '0;
      keys_q  <= '0;
      chg_q   <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      sync1_q <= keys_i_g;
      sync2_q <= sync1_q;
      work_q  <= work_d;
      keys_q  <= keys_d;
      chg_q   <= chg_d;
      cnt_q   <= cnt_d;
    end
  end

  tick_idle_a: assert property (
    @(posedge clk_g_int_buf) disable iff (!rstn_g_i)
    tick |-> state_q == IDLE
  );

endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan: directed phases plus random key patterns
// checked against a per-tick integrator model.
module tb_key_debounce_scan;
  localparam int N    = 61;
  localparam int CW   = 3;
  localparam int TD   = 80;
  localparam int MAXC = 7;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] pins = '1;
  logic [N-1:0] keys_o;
  logic         keys_changed_o;
  logic         scan_busy_o;
  logic         tick_o;

  key_debounce_scan #(
    .NUM_KEYS(N), .CNT_W(CW), .TICK_DIV(TD), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_g_int_buf (clk),
    .rstn_g_i      (rstn),
    .keys_i_g      (pins),
    .keys_o        (keys_o),
    .keys_changed_o(keys_changed_o),
    .scan_busy_o   (scan_busy_o),
    .tick_o        (tick_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_tick = -1;
  int strobes = 0;
  int cnt_m [N];
  logic [N-1:0] st_m;
  logic [N-1:0] pub_m;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) cnt_m[k] = 0;
    st_m  = '0;
    pub_m = '0;
  endtask

  // One sample tick: every key is a pressed/released vote on its counter.
  task automatic do_tick();
    int n = 0;
    logic [N-1:0] old_pub;
    bit exp_chg;
    bit busy_ok = 1'b1;
    bit early_ok = 1'b1;
    while (tick_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tick_o !== 1'b1) begin
      check("tick_timeout", N'(0), N'(1));
      return;
    end
    if (last_tick >= 0) check("tick_period", N'(cyc - last_tick), N'(TD));
    last_tick = cyc;
    for (int k = 0; k < N; k++) begin
      if (!pins[k]) cnt_m[k] = (cnt_m[k] < MAXC) ? cnt_m[k] + 1 : MAXC;
      else          cnt_m[k] = (cnt_m[k] > 0) ? cnt_m[k] - 1 : 0;
      if (cnt_m[k] == MAXC) st_m[k] = 1'b1;
      else if (cnt_m[k] == 0) st_m[k] = 1'b0;
    end
    old_pub = pub_m;
    exp_chg = (st_m != pub_m);
    pub_m   = st_m;
    for (int i = 1; i <= 62; i++) begin
      @(negedge clk);
      if (scan_busy_o !== 1'b1) busy_ok = 1'b0;
      if (i < 62 && (keys_o !== old_pub || keys_changed_o !== 1'b0))
        early_ok = 1'b0;
    end
    check("busy_62", N'(busy_ok), N'(1));
    check("no_early_publish", N'(early_ok), N'(1));
    check("keys_publish", keys_o, pub_m);
    check("changed_strobe", N'(keys_changed_o), N'(exp_chg));
    if (keys_changed_o === 1'b1) strobes++;
    @(negedge clk);
    check("idle_after", N'({scan_busy_o, keys_changed_o}), N'(0));
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) do_tick();
  endtask

  initial begin
    model_reset();
    pins = '1;
    repeat (3) @(negedge clk);
    check("reset_keys", keys_o, '0);
    check("reset_ctl", N'({keys_changed_o, scan_busy_o, tick_o}), N'(0));
    rstn = 1'b1;

    ticks(3);
    check("idle_keys", keys_o, '0);

    strobes = 0;
    pins[5] = 1'b0;
    ticks(6);
    check("k5_not_yet", N'(keys_o[5]), N'(0));
    ticks(2);
    check("k5_pressed", keys_o, N'(1) << 5);
    check("k5_one_strobe", N'(strobes), N'(1));

    strobes = 0;
    pins[5] = 1'b1;
    ticks(8);
    check("k5_released", keys_o, '0);
    check("k5_rel_strobe", N'(strobes), N'(1));

    strobes = 0;
    for (int t = 0; t < 40; t++) begin
      pins[60] = ~pins[60];
      do_tick();
    end
    check("bounce_k60", N'(keys_o[60]), N'(0));
    check("bounce_no_strobe", N'(strobes), N'(0));

    strobes = 0;
    pins[60] = 1'b0;
    pins[31] = 1'b0;
    pins[0]  = 1'b0;
    ticks(7);
    check("multi_press", keys_o, (N'(1) << 60) | (N'(1) << 31) | N'(1));
    check("multi_one_strobe", N'(strobes), N'(1));

    pins = '1;
    ticks(8);

    pins[10] = 1'b0;
    ticks(7);
    pins[5] = 1'b0;
    ticks(6);
    check("k5_cnt6", N'(cnt_m[5]), N'(6));
    while (tick_o !== 1'b1 && cyc < 2000000) @(negedge clk);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midscan_rst_keys", keys_o, '0);
    check("midscan_rst_ctl",
          N'({keys_changed_o, scan_busy_o, tick_o}), N'(0));
    model_reset();
    last_tick = -1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    ticks(6);
    check("k5_fresh_6", N'(keys_o[5]), N'(0));
    ticks(1);
    check("k5_fresh_7", keys_o, (N'(1) << 10) | (N'(1) << 5));

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(5) == 0) pins[k] = ~pins[k];
      end
      if ($urandom_range(1) == 0) ticks(1);
      else ticks(int'($urandom_range(8, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
